// File: rtl/com_identify_pkg.sv
// Shared constants and state encodings for the command-frame parser.
package com_identify_pkg;

  localparam logic [7:0] HDR1_BYTE   = 8'hEB;
  localparam logic [7:0] HDR2_BYTE   = 8'h90;
  localparam logic [7:0] TYPE_DATA   = 8'h01;
  localparam logic [7:0] TYPE_SWITCH = 8'h5A;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_FETCH,
    RD_SETTLE,
    RD_EMIT,
    RD_CMD
  } rd_state_e;

  typedef enum logic [2:0] {
    PS_HDR1,
    PS_HDR2,
    PS_TYPE,
    PS_LEN,
    PS_PAYLOAD,
    PS_CSUM
  } ps_state_e;

endpackage

// File: rtl/com_frame_buf.sv
// Payload store: MAX_LEN x 8 registers, synchronous write, combinational read.
// Storage is deliberately unreset; contents are only read after being written by the current frame.
module com_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/com_identify.sv
// Drains the receive FIFO after the frame gap (one byte per 2 cycles), validates EB 90 frames,
// forwards data payloads to the CPU UARTs and turns switch frames into force_swi/com_swi.
module com_identify
  import com_identify_pkg::*;
#(
  parameter int COUNTER_W = 5,
  parameter int MAX_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rec_command,
  input  logic [COUNTER_W-1:0] com_count,
  input  logic                 command_time_out,
  output logic                 com_pop,
  output logic [7:0]           tdr_cpuAB,
  output logic                 tf_push_cpuAB,
  output logic                 force_swi,
  output logic                 com_swi,
  output logic                 error
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam int         LW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rd_state_e       rd_q;
  ps_state_e       ps_q;
  logic [7:0]      type_q;
  logic [7:0]      csum_q;
  logic [7:0]      pay0_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   idx_q;
  logic [LW-1:0]   idx_nxt;
  logic            good_q;
  logic [7:0]      tdr_q;
  logic            push_q;
  logic            force_q;
  logic            swi_q;
  logic            err_q;
  logic            buf_we;
  logic [7:0]      buf_rdat;
  logic            type_ok;
  logic            fifo_has;

  assign idx_nxt  = idx_q + 1'b1;
  assign type_ok  = (type_q == TYPE_DATA) || (type_q == TYPE_SWITCH);
  assign fifo_has = (com_count != '0);
  assign buf_we   = (rd_q == RD_FETCH) && (ps_q == PS_PAYLOAD);

  com_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (rec_command),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= RD_IDLE;
      ps_q    <= PS_HDR1;
      type_q  <= '0;
      csum_q  <= '0;
      pay0_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      good_q  <= 1'b0;
      tdr_q   <= '0;
      push_q  <= 1'b0;
      force_q <= 1'b0;
      swi_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      push_q  <= 1'b0;
      force_q <= 1'b0;
      case (rd_q)
        RD_IDLE: begin
          if (command_time_out && fifo_has) rd_q <= RD_FETCH;
        end
        RD_FETCH: begin
          rd_q <= RD_SETTLE;
          case (ps_q)
            PS_HDR1: begin
              if (rec_command == HDR1_BYTE) ps_q <= PS_HDR2;
            end
            PS_HDR2: begin
              if (rec_command == HDR2_BYTE)      ps_q <= PS_TYPE;
              else if (rec_command != HDR1_BYTE) ps_q <= PS_HDR1;
            end
            PS_TYPE: begin
              type_q <= rec_command;
              csum_q <= rec_command;
              ps_q   <= PS_LEN;
            end
            PS_LEN: begin
              // Switch frames carry exactly one payload byte; anything else is rejected here.
              if ((rec_command > MAX_LEN_B) || !type_ok ||
                  ((type_q == TYPE_SWITCH) && (rec_command != 8'd1))) begin
                err_q <= 1'b1;
                ps_q  <= PS_HDR1;
              end else begin
                len_q  <= rec_command[LW-1:0];
                csum_q <= csum_q + rec_command;
                idx_q  <= '0;
                ps_q   <= (rec_command == 8'd0) ? PS_CSUM : PS_PAYLOAD;
              end
            end
            PS_PAYLOAD: begin
              csum_q <= csum_q + rec_command;
              if (idx_q == '0) pay0_q <= rec_command;
              idx_q <= idx_nxt;
              if (idx_nxt == len_q) ps_q <= PS_CSUM;
            end
            PS_CSUM: begin
              if (rec_command == csum_q) good_q <= 1'b1;
              else                       err_q  <= 1'b1;
              ps_q <= PS_HDR1;
            end
            default: ps_q <= PS_HDR1;
          endcase
        end
        RD_SETTLE: begin
          if (good_q) begin
            good_q <= 1'b0;
            idx_q  <= '0;
            rd_q   <= (type_q == TYPE_DATA) ? RD_EMIT : RD_CMD;
          end else if (fifo_has) begin
            rd_q <= RD_FETCH;
          end else begin
            rd_q <= RD_IDLE;
            if ((ps_q != PS_HDR1) && command_time_out) begin
              err_q <= 1'b1;
              ps_q  <= PS_HDR1;
            end
          end
        end
        RD_EMIT: begin
          if (len_q != '0) begin
            push_q <= 1'b1;
            tdr_q  <= buf_rdat;
          end
          idx_q <= idx_nxt;
          if ((len_q == '0) || (idx_nxt == len_q)) begin
            err_q <= 1'b0;
            rd_q  <= fifo_has ? RD_FETCH : RD_IDLE;
          end
        end
        RD_CMD: begin
          if (pay0_q[7:1] == 7'd0) begin
            swi_q   <= pay0_q[0];
            force_q <= 1'b1;
            err_q   <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
          rd_q <= fifo_has ? RD_FETCH : RD_IDLE;
        end
        default: rd_q <= RD_IDLE;
      endcase
    end
  end

  assign com_pop       = (rd_q == RD_FETCH);
  assign tdr_cpuAB     = tdr_q;
  assign tf_push_cpuAB = push_q;
  assign force_swi     = force_q;
  assign com_swi       = swi_q;
  assign error         = err_q;

endmodule

// File: tb/tb_com_identify.sv
// Directed-frame bench for com_identify with a behavioural receive FIFO.
module tb_com_identify;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rec_command = 8'h00;
  logic [4:0] com_count = 5'd0;
  logic       command_time_out = 1'b0;
  logic       com_pop;
  logic [7:0] tdr_cpuAB;
  logic       tf_push_cpuAB;
  logic       force_swi;
  logic       com_swi;
  logic       error;

  always #5 clk = ~clk;

  com_identify #(.COUNTER_W(5), .MAX_LEN(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .rec_command      (rec_command),
    .com_count        (com_count),
    .command_time_out (command_time_out),
    .com_pop          (com_pop),
    .tdr_cpuAB        (tdr_cpuAB),
    .tf_push_cpuAB    (tf_push_cpuAB),
    .force_swi        (force_swi),
    .com_swi          (com_swi),
    .error            (error)
  );

  logic [7:0] fifo[$];
  logic [7:0] tx[$];
  logic [7:0] pushed[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  logic       load = 1'b0;
  logic       pop_seen = 1'b0;
  int         n_pop = 0, n_force = 0, n_under = 0, cyc = 0;
  int         n_chk = 0, n_bad = 0;
  int         p0, q0, f0, c0;

  // FIFO model: a pop seen during FETCH retires the head at the following falling edge.
  always @(negedge clk) begin
    cyc++;
    if (pop_seen) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      else n_under++;
    end
    if (load) fifo = tx;
    pop_seen = com_pop && !rst;
    if (com_pop && !rst) begin
      n_pop++;
      pop_cyc.push_back(cyc);
    end
    if (tf_push_cpuAB) pushed.push_back(tdr_cpuAB);
    if (force_swi) n_force++;
    com_count   = 5'(fifo.size());
    rec_command = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_push(input string tag);
    chk({tag, "_npush"}, 32'(pushed.size() - q0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (q0 + i < pushed.size()) chk({tag, "_byte"}, 32'(pushed[q0 + i]), 32'(exp_q[i]));
  endtask

  task automatic snap();
    p0 = n_pop; q0 = pushed.size(); f0 = n_force; c0 = pop_cyc.size();
  endtask

  task automatic load_fifo();
    @(posedge clk); #1 load = 1'b1;
    @(negedge clk); #1 load = 1'b0;
  endtask

  task automatic drain();
    command_time_out = 1'b1;
    for (int i = 0; i < 400 && fifo.size() != 0; i++) @(posedge clk);
    chk("drain", 32'(fifo.size()), 32'd0);
    repeat (30) @(posedge clk);
    #1 command_time_out = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame();
    snap();
    load_fifo();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_outs", 32'({com_pop, tf_push_cpuAB, force_swi, com_swi, error, tdr_cpuAB}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    tx = '{8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    run_frame();
    chk("data_pops", 32'(n_pop - p0), 32'd8);
    if (pop_cyc.size() >= c0 + 8) chk("data_pop_span", 32'(pop_cyc[c0 + 7] - pop_cyc[c0]), 32'd14);
    exp_q = '{8'h11, 8'h22, 8'h33};
    chk_push("data");
    chk("data_err", 32'(error), 32'd0);

    tx = '{8'hEB, 8'h90, 8'h5A, 8'h01, 8'h01, 8'h5C};
    run_frame();
    chk("sw1_force", 32'(n_force - f0), 32'd1);
    chk("sw1_swi", 32'(com_swi), 32'd1);

    tx = '{8'hEB, 8'h90, 8'h5A, 8'h01, 8'h00, 8'h5B};
    run_frame();
    chk("sw0_force", 32'(n_force - f0), 32'd1);
    chk("sw0_swi", 32'(com_swi), 32'd0);

    tx = '{8'hEB, 8'h90, 8'h5A, 8'h01, 8'h02, 8'h5D};
    run_frame();
    chk("swbad_force", 32'(n_force - f0), 32'd0);
    chk("swbad_err", 32'(error), 32'd1);
    chk("swbad_swi", 32'(com_swi), 32'd0);

    tx = '{8'hEB, 8'h90, 8'h01, 8'h00, 8'h01};
    run_frame();
    chk("len0a_err", 32'(error), 32'd0);
    exp_q = {};
    chk_push("len0a");

    tx = '{8'hEB, 8'h90, 8'h01, 8'h01, 8'hAA, 8'h00};
    run_frame();
    chk("badcs_err", 32'(error), 32'd1);
    exp_q = {};
    chk_push("badcs");

    tx = '{8'hEB, 8'h90, 8'h01, 8'h00, 8'h01};
    run_frame();
    chk("len0b_err", 32'(error), 32'd0);
    exp_q = {};
    chk_push("len0b");

    tx = '{8'h55, 8'hEB, 8'hEB, 8'h90, 8'h01, 8'h01, 8'h7F, 8'h81};
    run_frame();
    chk("resync_pops", 32'(n_pop - p0), 32'd8);
    exp_q = '{8'h7F};
    chk_push("resync");
    chk("resync_err", 32'(error), 32'd0);

    tx = '{8'hEB, 8'h90, 8'h01, 8'h11, 8'h01, 8'h02, 8'h03};
    run_frame();
    chk("len17_err", 32'(error), 32'd1);
    chk("len17_pops", 32'(n_pop - p0), 32'd7);
    exp_q = {};
    chk_push("len17");

    tx = '{8'hEB, 8'h90, 8'h5A, 8'h01, 8'h01, 8'h5C};
    run_frame();
    chk("sw1b_err", 32'(error), 32'd0);
    chk("sw1b_swi", 32'(com_swi), 32'd1);

    tx = '{8'hEB, 8'h90, 8'h01, 8'h04, 8'h01};
    run_frame();
    chk("trunc_err", 32'(error), 32'd1);
    exp_q = {};
    chk_push("trunc");

    // Reset while a pop is being presented: nothing is lost from the FIFO and the parser restarts.
    tx = '{8'hEB, 8'h90, 8'h01, 8'h01, 8'h05, 8'h07};
    load_fifo();
    command_time_out = 1'b1;
    for (int i = 0; i < 50 && !com_pop; i++) begin
      @(posedge clk); #2;
    end
    chk("rst_fetch_seen", 32'(com_pop), 32'd1);
    rst = 1'b1;
    command_time_out = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({com_pop, tf_push_cpuAB, force_swi, com_swi, error, tdr_cpuAB}), 32'd0);
    snap();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("rst_no_pop", 32'(n_pop - p0), 32'd0);
    chk("rst_fifo_kept", 32'(fifo.size()), 32'd6);
    drain();
    exp_q = '{8'h05};
    chk_push("post_rst");
    chk("post_rst_err", 32'(error), 32'd0);

    chk("underflow", 32'(n_under), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
